// File: rtl/adder3_rr_sched_pkg.sv
// adder3_rr_sched_pkg
// Constants and helpers shared by the adder3_rr_sched scheduler and its
// sub-module.
//   FIFO_DEPTH  number of result slots buffered ahead of the consumer
//   idWidth()   width of a requester index, never narrower than one bit
package adder3_rr_sched_pkg;

  localparam int FIFO_DEPTH = 2;

  function automatic int idWidth(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder3_rr_sched_adder_3in.sv
// adder_3in
// Registered three-input unsigned adder with one cycle of latency and no reset.
// The result wraps modulo 2^SUM_WIDTH. Operands wider than the sum can be
// truncated before adding because only the low SUM_WIDTH bits survive anyway.
// Ports:
//   clk_i  clock
//   a_i    operand a, OP_WIDTH bits
//   b_i    operand b, OP_WIDTH bits
//   c_i    operand c, OP_WIDTH bits
//   sum_o  registered (a+b+c) mod 2^SUM_WIDTH
module adder_3in #(
  parameter int OP_WIDTH  = 18,
  parameter int SUM_WIDTH = 20
) (
  input  logic                 clk_i,
  input  logic [OP_WIDTH-1:0]  a_i,
  input  logic [OP_WIDTH-1:0]  b_i,
  input  logic [OP_WIDTH-1:0]  c_i,
  output logic [SUM_WIDTH-1:0] sum_o
);

  logic [SUM_WIDTH-1:0] sum_d;
  logic [SUM_WIDTH-1:0] sum_q;

  assign sum_d = SUM_WIDTH'(a_i) + SUM_WIDTH'(b_i) + SUM_WIDTH'(c_i);

  // The owner qualifies this output with its own valid bit, so no reset.
  always_ff @(posedge clk_i) begin
    sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/adder3_rr_sched.sv
// adder3_rr_sched
// Shares one registered 3-input adder among NREQ requesters. A round-robin
// arbiter grants at most one requester per cycle, the granted operands go
// through the adder, and the sums queue in a small FIFO in acceptance order.
// A grant is only given when a FIFO slot is guaranteed for the result.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_c    packed operands, requester i at [i*OP_WIDTH +: OP_WIDTH]
//   res_valid/res_ready  result handshake
//   res_sum/res_id       result value and index of the issuing requester
//   idle                 nothing requested, in flight or buffered
module adder3_rr_sched
  import adder3_rr_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int OP_WIDTH  = 18,
  parameter int SUM_WIDTH = 20,
  localparam int ID_WIDTH = idWidth(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_WIDTH-1:0] req_a,
  input  logic [NREQ*OP_WIDTH-1:0] req_b,
  input  logic [NREQ*OP_WIDTH-1:0] req_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SUM_WIDTH-1:0]     res_sum,
  output logic [ID_WIDTH-1:0]      res_id,
  output logic                     idle
);

  localparam int PTR_W = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_WIDTH-1:0]  rrPtr_q;
  logic [ID_WIDTH-1:0]  rrPtr_d;
  logic                 pipeValid_q;
  logic [ID_WIDTH-1:0]  pipeId_q;
  logic [SUM_WIDTH-1:0] fifoSum_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  fifoId_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q;
  logic [PTR_W-1:0]     rdPtr_q;
  logic [CNT_W-1:0]     fifoCount_q;
  logic [CNT_W-1:0]     fifoCount_d;

  logic                 found;
  logic [ID_WIDTH-1:0]  winner;
  logic                 pop;
  logic                 push;
  logic                 creditOk;
  logic                 handshake;
  logic [CNT_W:0]       usedSlots;
  logic [CNT_W:0]       freeLimit;
  logic [OP_WIDTH-1:0]  opA;
  logic [OP_WIDTH-1:0]  opB;
  logic [OP_WIDTH-1:0]  opC;
  logic [SUM_WIDTH-1:0] adderSum;

  assign pop  = res_valid & res_ready;
  assign push = pipeValid_q;

  // Every accepted op that has not yet been popped owns a slot: either it is
  // in the adder register or it sits in the FIFO. A pop this cycle frees one.
  assign usedSlots = {1'b0, fifoCount_q} + {{CNT_W{1'b0}}, pipeValid_q};
  assign freeLimit = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign creditOk  = usedSlots < freeLimit;

  // Round-robin search starting at rrPtr_q, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
      end
    end
  end

  assign req_ready = (!rst && found && creditOk) ? (NREQ'(1) << winner) : '0;
  assign handshake = |(req_valid & req_ready);

  assign opA = req_a[int'(winner)*OP_WIDTH +: OP_WIDTH];
  assign opB = req_b[int'(winner)*OP_WIDTH +: OP_WIDTH];
  assign opC = req_c[int'(winner)*OP_WIDTH +: OP_WIDTH];

  adder_3in #(
    .OP_WIDTH  (OP_WIDTH),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_adder (
    .clk_i (clk),
    .a_i   (opA),
    .b_i   (opB),
    .c_i   (opC),
    .sum_o (adderSum)
  );

  assign rrPtr_d = !handshake ? rrPtr_q :
                   (winner == ID_WIDTH'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    fifoCount_d = fifoCount_q;
    if (push && !pop) fifoCount_d = fifoCount_q + 1'b1;
    else if (!push && pop) fifoCount_d = fifoCount_q - 1'b1;
  end

  // Arbiter pointer and the in-flight tag that travels alongside the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q     <= '0;
      pipeValid_q <= 1'b0;
      pipeId_q    <= '0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      pipeValid_q <= handshake;
      pipeId_q    <= winner;
    end
  end

  // Result FIFO. Storage is reset so the outputs read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoSum_q[i] <= '0;
        fifoId_q[i]  <= '0;
      end
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
    end else begin
      if (push) begin
        fifoSum_q[wrPtr_q] <= adderSum;
        fifoId_q[wrPtr_q]  <= pipeId_q;
        wrPtr_q            <= wrPtr_q + 1'b1;
      end
      if (pop) rdPtr_q <= rdPtr_q + 1'b1;
      fifoCount_q <= fifoCount_d;
    end
  end

  assign res_valid = (fifoCount_q != '0);
  assign res_sum   = fifoSum_q[rdPtr_q];
  assign res_id    = fifoId_q[rdPtr_q];
  assign idle      = rst | (~|req_valid & ~pipeValid_q & (fifoCount_q == '0));

endmodule
